// File: rtl/tot_pkg.sv
// Shared types and widths for the TOT hit timestamping path.
package tot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STOP,
        DONE
    } state_t;

    localparam int FINE_W  = 3;
    localparam int THERM_W = 8;

    function automatic int ts_width(input int coarse_w);
        return coarse_w + FINE_W;
    endfunction

endpackage

// File: rtl/encode8b3b.sv
// Bubble-tolerant 8b thermometer to 3b fine encoder (combinational).
module encode8b3b
    import tot_pkg::*;
(
    input  logic [THERM_W-1:0] code,
    input  logic [2:0]         level,
    output logic [FINE_W-1:0]  fine,
    output logic               err
);

    logic [FINE_W-1:0] lo;
    logic [FINE_W-1:0] hi;
    logic [FINE_W-1:0] diff;
    logic              found;

    always_comb begin
        lo    = '0;
        hi    = '0;
        found = 1'b0;
        for (int i = 0; i < THERM_W; i++) begin
            if (code[i]) begin
                if (!found) lo = FINE_W'(i);
                hi    = FINE_W'(i);
                found = 1'b1;
            end
        end
    end

    // Spread between outermost set bits measures the bubble width.
    always_comb begin
        diff = hi - lo;
        err  = found && (diff >= level);
        if (!found)
            fine = '1;
        else if (err)
            fine = '0;
        else if (diff <= FINE_W'(1))
            fine = lo;
        else
            fine = lo + FINE_W'(1);
    end

endmodule

// File: rtl/tot_hit_timestamp.sv
// Captures start/stop edges of one hit and emits {TOA, TOT, error, timeout}
// through a valid/ready handshake.
module tot_hit_timestamp
    import tot_pkg::*;
#(
    parameter  int COARSE_W = 7,
    parameter  int TIMEOUT  = 63,
    localparam int TS_W     = ts_width(COARSE_W)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [2:0]          level,
    input  logic                start_valid,
    input  logic [THERM_W-1:0]  start_code,
    input  logic [COARSE_W-1:0] start_coarse,
    input  logic                stop_valid,
    input  logic [THERM_W-1:0]  stop_code,
    input  logic [COARSE_W-1:0] stop_coarse,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TS_W-1:0]     out_toa,
    output logic [TS_W-1:0]     out_tot,
    output logic                out_error,
    output logic                out_timeout,
    output logic                busy,
    output logic                hit_dropped
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept_start;
    logic              capture;
    logic              timeout_hit;
    logic              drop;

    logic [FINE_W-1:0] start_fine, stop_fine;
    logic              start_err_c, stop_err_c;
    logic [TS_W-1:0]   start_ts_c, stop_ts_c;
    logic [TS_W-1:0]   start_ts_p1;
    logic              start_err_p1;
    logic [TS_W-1:0]   toa_src;
    logic              err_src;

    encode8b3b u_enc_start (
        .code  (start_code),
        .level (level),
        .fine  (start_fine),
        .err   (start_err_c)
    );

    encode8b3b u_enc_stop (
        .code  (stop_code),
        .level (level),
        .fine  (stop_fine),
        .err   (stop_err_c)
    );

    assign start_ts_c = {start_coarse, start_fine};
    assign stop_ts_c  = {stop_coarse, stop_fine};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_start = 1'b0;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        drop         = 1'b0;
        case (state_q)
            WAIT_STOP: begin
                drop = start_valid;
                if (stop_valid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    capture     = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // A DONE word being consumed frees the block in the same cycle,
                // so IDLE and DONE-with-ready share the start acceptance rules.
                if (state_q == DONE && !out_ready) begin
                    drop = start_valid;
                end else if (start_valid) begin
                    accept_start = 1'b1;
                    if (stop_valid) begin
                        state_d = DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT_STOP;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign toa_src = (state_q == WAIT_STOP) ? start_ts_p1  : start_ts_c;
    assign err_src = (state_q == WAIT_STOP) ? start_err_p1 : start_err_c;

    // Stage p1: latched start edge and the registered result word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_ts_p1  <= '0;
            start_err_p1 <= 1'b0;
            out_toa      <= '0;
            out_tot      <= '0;
            out_error    <= 1'b0;
            out_timeout  <= 1'b0;
            hit_dropped  <= 1'b0;
        end else begin
            hit_dropped <= drop;
            if (accept_start) begin
                start_ts_p1  <= start_ts_c;
                start_err_p1 <= start_err_c;
            end
            if (capture) begin
                out_toa     <= toa_src;
                out_tot     <= timeout_hit ? '0 : (stop_ts_c - toa_src);
                out_error   <= timeout_hit ? err_src : (err_src | stop_err_c);
                out_timeout <= timeout_hit;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tot_hit_timestamp.sv
// Scoreboard bench for tot_hit_timestamp: directed test-plan hits plus
// randomized traffic against a cycle-level behavioural model.
module tb_tot_hit_timestamp;

    localparam int COARSE_W = 7;
    localparam int TIMEOUT  = 63;
    localparam int TS_W     = 10;

    logic                clk = 1'b0;
    logic                rstn;
    logic [2:0]          level;
    logic                start_valid;
    logic [7:0]          start_code;
    logic [COARSE_W-1:0] start_coarse;
    logic                stop_valid;
    logic [7:0]          stop_code;
    logic [COARSE_W-1:0] stop_coarse;
    logic                out_valid;
    logic                out_ready;
    logic [TS_W-1:0]     out_toa;
    logic [TS_W-1:0]     out_tot;
    logic                out_error;
    logic                out_timeout;
    logic                busy;
    logic                hit_dropped;

    always #5 clk = ~clk;

    tot_hit_timestamp #(.COARSE_W(COARSE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .level        (level),
        .start_valid  (start_valid),
        .start_code   (start_code),
        .start_coarse (start_coarse),
        .stop_valid   (stop_valid),
        .stop_code    (stop_code),
        .stop_coarse  (stop_coarse),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_toa      (out_toa),
        .out_tot      (out_tot),
        .out_error    (out_error),
        .out_timeout  (out_timeout),
        .busy         (busy),
        .hit_dropped  (hit_dropped)
    );

    typedef struct packed {
        logic [TS_W-1:0] toa;
        logic [TS_W-1:0] tot;
        logic            err;
        logic            to;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    checks   = 0;
    int    failures = 0;

    bit    mon_en    = 1'b0;
    bit    use_model = 1'b0;
    logic  pred_drop, pred_busy, pred_valid;
    logic  exp_drop  = 1'b0;
    logic  exp_busy  = 1'b0;
    logic  exp_valid = 1'b0;

    bit    m_waiting, m_pending, m_start_err;
    int    m_start_ts, m_start_cyc, cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Fine-code rule: spread of set bits vs level decides error / rounding.
    function automatic void ref_edge(input logic [7:0] code, input logic [6:0] coarse,
                                     output int ts, output bit err);
        int lo, hi, f;
        lo = -1;
        hi = -1;
        for (int i = 0; i < 8; i++) begin
            if (code[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) begin
            f   = 7;
            err = 1'b0;
        end else begin
            err = (hi - lo) >= int'(level);
            f   = err ? 0 : ((hi - lo) <= 1 ? lo : lo + 1);
        end
        ts = int'(coarse) * 8 + f;
    endfunction

    function automatic void finish_hit(input bit to, input int stop_ts, input bit stop_err);
        word_t w;
        w.toa = TS_W'(m_start_ts);
        w.tot = to ? '0 : TS_W'(((stop_ts - m_start_ts) % 1024 + 1024) % 1024);
        w.err = m_start_err | (to ? 1'b0 : stop_err);
        w.to  = to;
        m_pending = 1'b1;
        m_waiting = 1'b0;
        if (use_model) exp_q.push_back(w);
    endfunction

    function automatic void model_cycle();
        int sts, pts;
        bit serr, perr, free;
        ref_edge(start_code, start_coarse, sts, serr);
        ref_edge(stop_code, stop_coarse, pts, perr);
        if (m_pending && out_ready) m_pending = 1'b0;
        free      = !m_waiting && !m_pending;
        pred_drop = start_valid && !free;
        if (m_waiting) begin
            if (stop_valid)
                finish_hit(1'b0, pts, perr);
            else if (cyc - m_start_cyc == TIMEOUT)
                finish_hit(1'b1, 0, 1'b0);
        end else if (free && start_valid) begin
            m_start_ts  = sts;
            m_start_err = serr;
            if (stop_valid) begin
                finish_hit(1'b0, pts, perr);
            end else begin
                m_waiting   = 1'b1;
                m_start_cyc = cyc;
            end
        end
        pred_busy  = m_waiting || m_pending;
        pred_valid = m_pending;
        cyc++;
    endfunction

    task automatic step(input bit sv, input logic [7:0] sc, input logic [6:0] scr,
                        input bit pv, input logic [7:0] pc, input logic [6:0] pcr,
                        input bit rdy);
        start_valid  = sv;
        start_code   = sc;
        start_coarse = scr;
        stop_valid   = pv;
        stop_code    = pc;
        stop_coarse  = pcr;
        out_ready    = rdy;
        model_cycle();
        @(posedge clk);
        exp_drop  = pred_drop;
        exp_busy  = pred_busy;
        exp_valid = pred_valid;
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 7'd0, 1'b0, 8'h00, 7'd0, rdy);
    endtask

    task automatic push_exp(input int toa, input int tot, input bit err, input bit to);
        word_t w;
        w.toa = TS_W'(toa);
        w.tot = TS_W'(tot);
        w.err = err;
        w.to  = to;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start_valid = 1'b0; start_code = '0; start_coarse = '0;
        stop_valid  = 1'b0; stop_code  = '0; stop_coarse  = '0;
        out_ready   = 1'b0;
        m_waiting = 1'b0; m_pending = 1'b0;
        exp_q.delete();
        @(posedge clk);
        exp_drop = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
        #1;
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_toa",     32'(out_toa),     32'd0);
        check("rst_out_tot",     32'(out_tot),     32'd0);
        check("rst_out_error",   32'(out_error),   32'd0);
        check("rst_out_timeout", 32'(out_timeout), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_hit_dropped", 32'(hit_dropped), 32'd0);
        rstn = 1'b1;
    endtask

    function automatic logic [7:0] rand_code();
        int len, pos;
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 255));
            1: return 8'h00;
            default: begin
                len = $urandom_range(1, 3);
                pos = $urandom_range(0, 7);
                return 8'(((1 << len) - 1) << pos);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("hit_dropped", 32'(hit_dropped), 32'(exp_drop));
            check("busy",        32'(busy),        32'(exp_busy));
            check("out_valid",   32'(out_valid),   32'(exp_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word_unexpected actual_toa=%0d actual_tot=%0d expected=none",
                             out_toa, out_tot);
                end else begin
                    mon_w = exp_q[0];
                    check("out_toa",     32'(out_toa),     32'(mon_w.toa));
                    check("out_tot",     32'(out_tot),     32'(mon_w.tot));
                    check("out_error",   32'(out_error),   32'(mon_w.err));
                    check("out_timeout", 32'(out_timeout), 32'(mon_w.to));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int stop_pct;
        cyc   = 0;
        level = 3'd3;
        do_reset();
        mon_en = 1'b1;

        // Basic hit: 5/01 -> ts 40, stop three cycles later 9/18 -> ts 75.
        step(1'b1, 8'h01, 7'd5, 1'b0, 8'h00, 7'd0, 1'b1);
        idle(2, 1'b1);
        push_exp(40, 35, 1'b0, 1'b0);
        step(1'b0, 8'h00, 7'd0, 1'b1, 8'h18, 7'd9, 1'b1);
        idle(2, 1'b1);

        // Coarse wrap: 1019 -> 16 gives 21.
        step(1'b1, 8'h18, 7'd127, 1'b0, 8'h00, 7'd0, 1'b1);
        push_exp(1019, 21, 1'b0, 1'b0);
        step(1'b0, 8'h00, 7'd0, 1'b1, 8'h01, 7'd2, 1'b1);
        idle(2, 1'b1);

        // Bubble error on start: fine forced to 0.
        step(1'b1, 8'h81, 7'd10, 1'b0, 8'h00, 7'd0, 1'b1);
        push_exp(80, 19, 1'b1, 1'b0);
        step(1'b0, 8'h00, 7'd0, 1'b1, 8'h18, 7'd12, 1'b1);
        idle(2, 1'b1);

        // Timeout: no stop for TIMEOUT cycles.
        push_exp(160, 0, 1'b0, 1'b1);
        step(1'b1, 8'h01, 7'd20, 1'b0, 8'h00, 7'd0, 1'b1);
        idle(TIMEOUT + 2, 1'b1);

        // Stop on the last permitted cycle is still accepted.
        push_exp(240, 83, 1'b0, 1'b0);
        step(1'b1, 8'h01, 7'd30, 1'b0, 8'h00, 7'd0, 1'b1);
        idle(TIMEOUT - 1, 1'b1);
        step(1'b0, 8'h00, 7'd0, 1'b1, 8'h18, 7'd40, 1'b1);
        idle(2, 1'b1);

        // Simultaneous start+stop, then backpressure with refused starts.
        push_exp(24, 3, 1'b0, 1'b0);
        step(1'b1, 8'h01, 7'd3, 1'b1, 8'h18, 7'd3, 1'b0);
        for (int i = 0; i < 10; i++)
            step(i % 2 == 0, 8'h01, 7'd7, 1'b0, 8'h00, 7'd0, 1'b0);
        step(1'b1, 8'h01, 7'd50, 1'b0, 8'h00, 7'd0, 1'b1);
        push_exp(400, 8, 1'b0, 1'b0);
        step(1'b0, 8'h00, 7'd0, 1'b1, 8'h01, 7'd51, 1'b1);
        idle(3, 1'b1);

        // Reset during WAIT_STOP discards the hit.
        step(1'b1, 8'h01, 7'd60, 1'b0, 8'h00, 7'd0, 1'b1);
        idle(5, 1'b1);
        do_reset();
        idle(5, 1'b1);

        // Randomized traffic checked by the model.
        use_model = 1'b1;
        for (int lv = 1; lv <= 3; lv++) begin
            level = 3'(lv);
            for (int ph = 0; ph < 2; ph++) begin
                stop_pct = (ph == 0) ? 20 : 1;
                for (int n = 0; n < 500; n++)
                    step($urandom_range(0, 3) == 0, rand_code(), 7'($urandom_range(0, 127)),
                         $urandom_range(0, 99) < stop_pct, rand_code(), 7'($urandom_range(0, 127)),
                         $urandom_range(0, 3) != 0);
                idle(TIMEOUT + 3, 1'b1);
            end
        end

        idle(5, 1'b1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tot_hit_timestamp.md
Name: tot_hit_timestamp

Overview:
- Downstream consumer of the 8b thermometer-to-3b binary fine encoder in the TOT encoder path.
- Captures one start edge (TOA) and one stop edge per hit. Each edge carries a raw 8b fine thermometer code and a coarse counter value.
- Encodes both fine codes and forms 10b timestamps {coarse, fine}. Computes TOT = stop − start modulo 2^(COARSE_W+3).
- Emits one result word per hit through a valid/ready handshake, with an error flag and a timeout flag.

Parameters:
- COARSE_W, 7, coarse counter width; timestamp width TS_W = COARSE_W+3.
- TIMEOUT, 63, maximum cycles to wait for a stop after start acceptance (≥1).

Ports:
- clk  in  1  block clock
- rstn  in  1  reset, synchronous, active-low
- level  in  3  bubble tolerance passed to both fine encoders (legal 1..3)
- start_valid  in  1  start edge present this cycle
- start_code  in  8  start fine thermometer code
- start_coarse  in  COARSE_W  start coarse count
- stop_valid  in  1  stop edge present this cycle
- stop_code  in  8  stop fine thermometer code
- stop_coarse  in  COARSE_W  stop coarse count
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts result
- out_toa  out  TS_W  start timestamp {start_coarse, fine}
- out_tot  out  TS_W  (stop_ts − start_ts) mod 2^TS_W; 0 on timeout
- out_error  out  1  either fine encoder flagged error
- out_timeout  out  1  no stop arrived within TIMEOUT cycles
- busy  out  1  state ≠ IDLE
- hit_dropped  out  1  one-cycle pulse: start_valid refused

Behaviour:
- Reset is synchronous and active-low: rstn=0 at a clk edge → state IDLE, wait counter 0. All outputs 0 (out_valid, out_toa, out_tot, out_error, out_timeout, busy, hit_dropped).
- Fine encoding per edge matches the team encoder. The error flag is set when (highest set bit − lowest set bit) ≥ level. On error the fine value is forced to 0. Otherwise fine = low index if diff ≤ 1, else low index + 1. All-zero code → fine 7, no error.
- States: IDLE, WAIT_STOP, DONE.
- IDLE, start_valid=1: latch start_ts and start_err.
  - If stop_valid=1 in the same cycle: also latch the stop and go to DONE.
  - Otherwise: go to WAIT_STOP with counter := 0.
- IDLE, stop_valid alone: ignored, no flag.
- WAIT_STOP, stop_valid=1: latch stop_ts and stop_err, go to DONE.
  - start_valid in any WAIT_STOP cycle is refused: hit_dropped=1 next cycle.
- WAIT_STOP, no stop:
  - counter < TIMEOUT−1: counter increments.
  - counter == TIMEOUT−1: go to DONE with timeout=1 and tot=0.
  - Net timing: a stop is accepted in cycles N+1..N+TIMEOUT after start acceptance at cycle N.
- DONE: out_valid=1. Word fields are stable while out_valid=1 and out_ready=0.
  - out_ready=1 → leave DONE.
  - If start_valid=1 in that same cycle, it is accepted (zero bubble) under the IDLE rules; otherwise go to IDLE.
  - start_valid while out_ready=0 is refused and pulses hit_dropped.
- Latency: stop accepted at cycle N → out_valid at N+1.
- out_error = start_err | stop_err. On timeout, out_error = start_err.
- TOT subtraction is TS_W-bit unsigned modular, so coarse wrap needs no special case.
- Reset mid-hit discards partial state with no output.
- Changing level mid-hit is not supported; level is sampled per edge.

Decomposition:
- Package tot_pkg:
  - state enum {IDLE, WAIT_STOP, DONE}
  - FINE_W=3, THERM_W=8
  - function ts_width(coarse_w)
- Sub-module: two instances of the existing encode8b3b (start and stop), combinational, registered by this block.

Test Plan:
- Basic hit, level=3: start coarse=5, code 8'h01 (fine 0); stop at cycle +3, coarse=9, code 8'h18 (fine 3) → one cycle later out_toa=40, out_tot=35, error=0, timeout=0.
- Coarse wrap: start coarse=127, code 8'h18 (ts 1019); stop coarse=2, code 8'h01 (ts 16) → out_tot=21.
- Bubble error, level=3: start code 8'h81 (diff 7) → out_error=1, out_toa fine field=0; rest of word correct.
- Timeout, TIMEOUT=63: start, no stop for 63 cycles → out_valid at start+64 with out_timeout=1, out_tot=0. A stop at start+63 is instead accepted normally.
- Backpressure: hold out_ready=0 for 10 cycles with start_valid pulses → word stable, hit_dropped pulses once per refused start. Raise out_ready with start_valid=1 → new start accepted in the same cycle, busy stays 1.
- Simultaneous start+stop in IDLE (coarse 3 both, codes 01/18) → out_tot=3 next cycle. rstn=0 during WAIT_STOP → IDLE, no output.
